pdm_cic_decim: RTL



---
 rtl/pdm_cic_decim.sv | 98 +++++++++
 1 files changed

// File: rtl/pdm_cic_decim.sv
// pdm_cic_decim: third-order CIC decimator, 1-bit PDM in, signed 16-bit PCM out.
// The integrators run on every input sample (cke). The combs and the output
// register run once per R samples, one clk after the decimation strobe.
module pdm_cic_decim #(
  parameter int N      = 3,
  parameter int R_LOG2 = 6,
  parameter int W      = N * R_LOG2 + 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cke,
  input  logic               din,
  output logic signed [15:0] dout,
  output logic               dout_valid
);

  // Shift that brings the R^N full-scale gain down to 16-bit full scale.
  localparam int SH = N * R_LOG2 - 15;
  localparam logic [R_LOG2-1:0]   CNT_LAST = '1;
  localparam logic signed [W-1:0] POS_MAX  = W'(32767);
  localparam logic signed [W-1:0] NEG_MIN  = -W'(32768);

  logic signed [W-1:0] x;
  logic signed [W-1:0] int1_q, int2_q, int3_q;
  logic signed [W-1:0] int1_d, int2_d, int3_d;
  logic signed [W-1:0] d1_q, d2_q, d3_q;
  logic signed [W-1:0] c0, c1, c2, c3, scaled;
  logic [R_LOG2-1:0]   cnt_q;
  logic                dec_q;
  logic signed [15:0]  dout_q, dout_d;
  logic                dout_valid_q;

  // Input mapping and cascaded integrator next values (each stage sees the
  // freshly updated value of the stage before it).
  always_comb begin
    x      = din ? W'(1) : {W{1'b1}};
    int1_d = int1_q + x;
    int2_d = int2_q + int1_d;
    int3_d = int3_q + int2_d;
  end

  // Comb chain on the current int3 and output saturation.
  always_comb begin
    c0     = int3_q;
    c1     = c0 - d1_q;
    c2     = c1 - d2_q;
    c3     = c2 - d3_q;
    scaled = c3 >>> SH;
    if (scaled > POS_MAX)
      dout_d = 16'sh7fff;
    else if (scaled < NEG_MIN)
      dout_d = -16'sh8000;
    else
      dout_d = scaled[15:0];
  end

  // Integrators, decimation counter and decimation strobe, advanced on cke.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int1_q <= '0;
      int2_q <= '0;
      int3_q <= '0;
      cnt_q  <= '0;
      dec_q  <= 1'b0;
    end else begin
      dec_q <= cke && (cnt_q == CNT_LAST);
      if (cke) begin
        int1_q <= int1_d;
        int2_q <= int2_d;
        int3_q <= int3_d;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  // Comb delay update and output register load, once per decimated frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_q         <= '0;
      d2_q         <= '0;
      d3_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= dec_q;
      if (dec_q) begin
        d1_q   <= c0;
        d2_q   <= c1;
        d3_q   <= c2;
        dout_q <= dout_d;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule
